ray_march_stepper: RTL and testbench

RAY_MARCH_STEPPER -- requirements
Module: ray_march_stepper

---
 rtl/ray_march_stepper_pkg.sv | 56 +++++
 rtl/march_wait_counter.sv | 27 ++
 rtl/ray_march_stepper.sv | 175 +++++++++++++++++
 tb/tb_ray_march_stepper.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_march_stepper_pkg.sv
// Shared types for the ray march stepper: Q16.16 fixed point, vec3, FSM states
// and the fp/vec3 arithmetic helpers used by the datapath.
package ray_march_stepper_pkg;

  localparam int FP_FRAC = 16;

  typedef logic signed [31:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  localparam fp FP_ZERO     = 32'sh0000_0000;
  localparam fp FP_ONE      = 32'sh0001_0000;
  localparam fp FP_EPSILON  = 32'sh0000_0100;  // 1/256
  localparam fp FP_MAX_DIST = 32'sh0010_0000;  // 16.0

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StStep,
    StDone
  } state_e;

  // Wrapping two's complement add.
  function automatic fp fp_add(input fp a, input fp b);
    return a + b;
  endfunction

  // Full-precision product, truncated back to Q16.16 (arithmetic, no rounding).
  function automatic fp fp_mul(input fp a, input fp b);
    logic signed [63:0] prod;
    prod = a * b;
    return prod[FP_FRAC +: 32];
  endfunction

  function automatic vec3 vec3_add(input vec3 a, input vec3 b);
    vec3 r;
    r.x = fp_add(a.x, b.x);
    r.y = fp_add(a.y, b.y);
    r.z = fp_add(a.z, b.z);
    return r;
  endfunction

  function automatic vec3 vec3_scale(input vec3 v, input fp s);
    vec3 r;
    r.x = fp_mul(v.x, s);
    r.y = fp_mul(v.y, s);
    r.z = fp_mul(v.z, s);
    return r;
  endfunction

endpackage

// File: rtl/march_wait_counter.sv
// SDF latency counter: loaded with the wait length, counts down one per
// cycle while enabled and flags the last wait cycle.
module march_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       dec,
  output logic       expired
);

  logic [5:0] count_q;

  // Count register: load wins over decrement; never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 6'd0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != 6'd0)) begin
      count_q <= count_q - 6'd1;
    end
  end

  assign expired = (count_q == 6'd1);

endmodule

// File: rtl/ray_march_stepper.sv
// Sphere-tracing ray marcher: issues query points to an external SDF block,
// waits a programmable latency, then steps along the ray until hit, miss by
// distance, or step budget exhausted.
// Optional feature macro RAY_MARCH_STEP_COUNT_EN adds the steps_out port.
module ray_march_stepper
  import ray_march_stepper_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 64,
  parameter fp           EPSILON   = FP_EPSILON,
  parameter fp           MAX_DIST  = FP_MAX_DIST
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  output logic       ready_out,
  input  vec3        origin_in,
  input  vec3        dir_in,
  output vec3        point_out,
  input  fp          sdf_in,
  input  logic [5:0] sdf_wait_max_in,
  output logic       valid_out,
  input  logic       result_ready_in,
  output logic       hit_out,
  output fp          t_out,
  output vec3        hit_point_out
`ifdef RAY_MARCH_STEP_COUNT_EN
  ,
  output logic [7:0] steps_out
`endif
);

  state_e     state_q, state_d;
  vec3        dir_q, dir_d;
  vec3        point_q, point_d;
  logic [5:0] wait_max_q, wait_max_d;
  fp          t_q, t_d;
  fp          sdf_q, sdf_d;
  logic [7:0] step_q, step_d;
  logic       hit_q, hit_d;
`ifdef RAY_MARCH_STEP_COUNT_EN
  logic [7:0] steps_q, steps_d;
`endif

  logic cnt_load;
  logic cnt_dec;
  logic cnt_expired;
  fp    t_plus;
  logic step_last;

  march_wait_counter u_wait_counter (
    .clk      (clk_in),
    .rst      (rst_in),
    .load     (cnt_load),
    .load_val (wait_max_q),
    .dec      (cnt_dec),
    .expired  (cnt_expired)
  );

  assign t_plus    = fp_add(t_q, sdf_q);
  assign step_last = ((32'(step_q) + 32'd1) == MAX_STEPS);

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    point_d    = point_q;
    wait_max_d = wait_max_q;
    t_d        = t_q;
    sdf_d      = sdf_q;
    step_d     = step_q;
    hit_d      = hit_q;
`ifdef RAY_MARCH_STEP_COUNT_EN
    steps_d    = steps_q;
`endif
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          dir_d      = dir_in;
          point_d    = origin_in;
          // A zero latency would never expire; run it as a single wait cycle.
          wait_max_d = (sdf_wait_max_in == 6'd0) ? 6'd1 : sdf_wait_max_in;
          t_d        = FP_ZERO;
          step_d     = 8'd0;
          hit_d      = 1'b0;
`ifdef RAY_MARCH_STEP_COUNT_EN
          steps_d    = 8'd0;
`endif
          state_d    = StIssue;
        end
      end
      StIssue: begin
        cnt_load = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        cnt_dec = 1'b1;
        if (cnt_expired) begin
          sdf_d   = sdf_in;
          state_d = StStep;
        end
      end
      StStep: begin
`ifdef RAY_MARCH_STEP_COUNT_EN
        steps_d = steps_q + 8'd1;
`endif
        if (sdf_q < EPSILON) begin
          hit_d   = 1'b1;
          state_d = StDone;
        end else if (t_plus > MAX_DIST) begin
          hit_d   = 1'b0;
          state_d = StDone;
        end else if (step_last) begin
          hit_d   = 1'b0;
          state_d = StDone;
        end else begin
          t_d     = t_plus;
          point_d = vec3_add(point_q, vec3_scale(dir_q, sdf_q));
          step_d  = step_q + 8'd1;
          state_d = StIssue;
        end
      end
      StDone: begin
        if (result_ready_in) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      dir_q      <= '0;
      point_q    <= '0;
      wait_max_q <= 6'd0;
      t_q        <= FP_ZERO;
      sdf_q      <= FP_ZERO;
      step_q     <= 8'd0;
      hit_q      <= 1'b0;
`ifdef RAY_MARCH_STEP_COUNT_EN
      steps_q    <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      point_q    <= point_d;
      wait_max_q <= wait_max_d;
      t_q        <= t_d;
      sdf_q      <= sdf_d;
      step_q     <= step_d;
      hit_q      <= hit_d;
`ifdef RAY_MARCH_STEP_COUNT_EN
      steps_q    <= steps_d;
`endif
    end
  end

  assign ready_out     = (state_q == StIdle);
  assign valid_out     = (state_q == StDone);
  assign hit_out       = hit_q;
  assign t_out         = t_q;
  assign point_out     = point_q;
  assign hit_point_out = point_q;
`ifdef RAY_MARCH_STEP_COUNT_EN
  assign steps_out     = steps_q;
`endif

endmodule

// File: tb/tb_ray_march_stepper.sv
// Self-checking bench: two DUTs (MAX_STEPS 64 and 4) share stimulus; a
// behavioural sphere-tracing model predicts result, latency and step count.
module tb_ray_march_stepper;
  import ray_march_stepper_pkg::*;

  localparam fp      TB_EPS  = 32'sd256;
  localparam longint TB_MAXD = 64'sd1048576;
  localparam int     BUDGET  = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       result_ready = 1'b0;
  vec3        origin = '0;
  vec3        dir = '0;
  logic [5:0] wait_max = 6'd0;
  fp          sdf;
  fp          const_sdf = '0;
  int         sdf_mode = 0;

  logic ready_a, valid_a, hit_a, ready_b, valid_b, hit_b;
  fp    t_a, t_b;
  vec3  point_a, point_b, hp_a, hp_b;
`ifdef RAY_MARCH_STEP_COUNT_EN
  logic [7:0] steps_a, steps_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ray_march_stepper dut_a (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start),
    .ready_out       (ready_a),
    .origin_in       (origin),
    .dir_in          (dir),
    .point_out       (point_a),
    .sdf_in          (sdf),
    .sdf_wait_max_in (wait_max),
    .valid_out       (valid_a),
    .result_ready_in (result_ready),
    .hit_out         (hit_a),
    .t_out           (t_a),
    .hit_point_out   (hp_a)
`ifdef RAY_MARCH_STEP_COUNT_EN
    , .steps_out     (steps_a)
`endif
  );

  ray_march_stepper #(.MAX_STEPS(4)) dut_b (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start),
    .ready_out       (ready_b),
    .origin_in       (origin),
    .dir_in          (dir),
    .point_out       (point_b),
    .sdf_in          (sdf),
    .sdf_wait_max_in (wait_max),
    .valid_out       (valid_b),
    .result_ready_in (result_ready),
    .hit_out         (hit_b),
    .t_out           (t_b),
    .hit_point_out   (hp_b)
`ifdef RAY_MARCH_STEP_COUNT_EN
    , .steps_out     (steps_b)
`endif
  );

  function automatic fp to_fp(input real r);
    return fp'($rtoi(r * 65536.0));
  endfunction

  // Unit cube |p| <= 0.5, evaluated in real arithmetic.
  function automatic fp cube_sdf(input vec3 p);
    real q[3];
    real o;
    real inner;
    fp   c[3];
    c[0] = p.x; c[1] = p.y; c[2] = p.z;
    o = 0.0;
    inner = -1.0e9;
    for (int i = 0; i < 3; i++) begin
      q[i] = ((c[i] < 0) ? -$itor(c[i]) : $itor(c[i])) / 65536.0 - 0.5;
      if (q[i] > 0.0) o = o + q[i] * q[i];
      if (q[i] > inner) inner = q[i];
    end
    if (inner > 0.0) inner = 0.0;
    return to_fp($sqrt(o) + inner);
  endfunction

  // SDF block: both DUTs march in lockstep until dut_b runs out of steps.
  assign sdf = (sdf_mode == 1) ? cube_sdf(point_a) : const_sdf;

  function automatic fp tb_mul(input fp a, input fp b);
    longint prod;
    prod = longint'(a) * longint'(b);
    return fp'(prod >>> 16);
  endfunction

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference sphere tracer: returns outcome, final t/point, step count, latency.
  task automatic model(input vec3 org, input vec3 dr, input int max_steps, input int w,
                       input int mode, input fp cval, output logic hit, output fp t,
                       output vec3 p, output int n, output int lat);
    longint tt;
    fp      d;
    tt = 0;
    p = org;
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      d = (mode == 1) ? cube_sdf(p) : cval;
      n++;
      if (d < TB_EPS) begin
        hit = 1'b1;
        break;
      end
      if (tt + longint'(d) > TB_MAXD) break;
      if (n == max_steps) break;
      tt = tt + longint'(d);
      p.x = p.x + tb_mul(dr.x, d);
      p.y = p.y + tb_mul(dr.y, d);
      p.z = p.z + tb_mul(dr.z, d);
    end
    t = fp'(tt);
    lat = n * (((w == 0) ? 1 : w) + 2) + 1;
  endtask

  function automatic vec3 rand_vec(input int span);
    vec3 v;
    v.x = fp'(int'($urandom_range(0, 2 * span)) - span);
    v.y = fp'(int'($urandom_range(0, 2 * span)) - span);
    v.z = fp'(int'($urandom_range(0, 2 * span)) - span);
    return v;
  endfunction

  task automatic run_ray(input string tag, input vec3 org, input vec3 dr, input logic [5:0] w,
                         input int mode, input fp cval, input bit hold);
    logic hm_a, hm_b;
    fp    tm_a, tm_b;
    vec3  pm_a, pm_b;
    int   n_a, n_b, lat_a, lat_b;
    int   seen_a, seen_b;
    model(org, dr, 64, int'(w), mode, cval, hm_a, tm_a, pm_a, n_a, lat_a);
    model(org, dr, 4, int'(w), mode, cval, hm_b, tm_b, pm_b, n_b, lat_b);
    sdf_mode = mode;
    const_sdf = cval;
    @(negedge clk);
    check({tag, "_ready"}, 64'(ready_a & ready_b), 1);
    origin = org; dir = dr; wait_max = w; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Inputs change mid-march; the ray must not notice.
    start = 1'b0;
    origin = rand_vec(200000);
    dir = rand_vec(65536);
    wait_max = 6'($urandom_range(0, 63));
    seen_a = -1;
    seen_b = -1;
    for (int e = 1; e < BUDGET; e++) begin
      if (valid_a && seen_a < 0) seen_a = e;
      if (valid_b && seen_b < 0) seen_b = e;
      if (seen_a >= 0 && seen_b >= 0) break;
      @(negedge clk);
    end
    check({tag, "_lat_a"}, seen_a, lat_a);
    check({tag, "_lat_b"}, seen_b, lat_b);
    check({tag, "_hit_a"}, 64'(hit_a), 64'(hm_a));
    check({tag, "_t_a"}, t_a, tm_a);
    check({tag, "_px_a"}, hp_a.x, pm_a.x);
    check({tag, "_py_a"}, hp_a.y, pm_a.y);
    check({tag, "_pz_a"}, hp_a.z, pm_a.z);
    check({tag, "_hit_b"}, 64'(hit_b), 64'(hm_b));
    check({tag, "_t_b"}, t_b, tm_b);
    check({tag, "_pz_b"}, hp_b.z, pm_b.z);
`ifdef RAY_MARCH_STEP_COUNT_EN
    check({tag, "_steps_a"}, 64'(steps_a), n_a);
    check({tag, "_steps_b"}, 64'(steps_b), n_b);
`endif
    if (hold) begin
      start = 1'b1;
      origin = rand_vec(100000);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, 64'(valid_a), 1);
        check({tag, "_hold_ready"}, 64'(ready_a), 0);
        check({tag, "_hold_t"}, t_a, tm_a);
        check({tag, "_hold_pz"}, hp_a.z, pm_a.z);
      end
      start = 1'b0;
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    check({tag, "_consumed_ready"}, 64'(ready_a), 1);
    check({tag, "_consumed_valid"}, 64'(valid_a | valid_b), 0);
  endtask

  task automatic run_random(input int idx);
    vec3  org, dr, tgt;
    real  dx, dy, dz, len;
    int   mode;
    fp    cval;
    org = rand_vec(4 * 65536);
    tgt = rand_vec(26000);
    dx = $itor(tgt.x - org.x);
    dy = $itor(tgt.y - org.y);
    dz = $itor(tgt.z - org.z);
    len = $sqrt(dx * dx + dy * dy + dz * dz);
    if (len < 1000.0) begin
      dx = 0.0; dy = 0.0; dz = 1.0; len = 1.0;
    end
    dr.x = to_fp(dx / len);
    dr.y = to_fp(dy / len);
    dr.z = to_fp(dz / len);
    mode = ($urandom_range(0, 9) < 7) ? 1 : 0;
    cval = fp'(int'($urandom_range(0, 72000)) - 6554);
    run_ray($sformatf("rnd%0d", idx), org, dr, 6'($urandom_range(0, 7)), mode, cval, 1'b0);
  endtask

  initial begin
    vec3 zero_v, org_c, dir_z, dir_y;
    int  cnt;
    zero_v = '0;
    org_c = '0; org_c.z = to_fp(-3.0);
    dir_z = '0; dir_z.z = FP_ONE;
    dir_y = '0; dir_y.y = FP_ONE;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ready_a), 1);
    check("rst_valid", 64'(valid_a), 0);
    check("rst_hit", 64'(hit_a), 0);
    check("rst_t", t_a, 0);
    check("rst_point", 64'(point_a.z | point_a.x | point_a.y), 0);
    check("rst_hp", 64'(hp_a.z | hp_a.x | hp_a.y), 0);
    rst = 1'b0;

    run_ray("wait4", zero_v, dir_z, 6'd4, 0, FP_ZERO, 1'b0);
    check("wait4_hit", 64'(hit_a), 1);
    check("wait4_t", t_a, 0);

    run_ray("cube", org_c, dir_z, 6'd1, 1, FP_ZERO, 1'b1);
    check("cube_t_eps", 64'((t_a - to_fp(2.5)) <= TB_EPS && (to_fp(2.5) - t_a) <= TB_EPS), 1);
    check("cube_z_eps", 64'((hp_a.z - to_fp(-0.5)) <= TB_EPS
                            && (to_fp(-0.5) - hp_a.z) <= TB_EPS), 1);
    check("cube_hit", 64'(hit_a), 1);

    run_ray("miss", org_c, dir_y, 6'd1, 1, FP_ZERO, 1'b0);
    check("miss_hit", 64'(hit_a), 0);
    check("miss_over", 64'(longint'(t_a) + longint'(cube_sdf(hp_a)) > TB_MAXD), 1);

    run_ray("budget", zero_v, dir_z, 6'd2, 0, to_fp(0.25), 1'b0);
    check("budget_hit_b", 64'(hit_b), 0);
    check("budget_t_b", t_b, to_fp(0.75));
`ifdef RAY_MARCH_STEP_COUNT_EN
    check("budget_steps_b", 64'(steps_b), 4);
`endif

    run_ray("wait0", zero_v, dir_z, 6'd0, 0, -32'sd100, 1'b0);

    for (int i = 0; i < 16; i++) run_random(i);

    // Reset while waiting on the SDF block abandons the ray.
    sdf_mode = 1;
    @(negedge clk);
    origin = org_c; dir = dir_z; wait_max = 6'd20; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 64'(ready_a), 1);
    check("midrst_valid", 64'(valid_a), 0);
    check("midrst_t", t_a, 0);
    check("midrst_point", 64'(point_a.z), 0);
    check("midrst_hit", 64'(hit_a), 0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_a || valid_b || !ready_a) cnt++;
    end
    check("midrst_no_valid", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
